// File: rtl/watch_set_ctrl_if.sv
// Bus between the watch counter / display side (master) and the time-setting controller (slave).
// Raw buttons and the live time flow into the controller; edited time, load strobe and blink mask flow out.
interface watch_set_ctrl_if;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [3:0] cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one;
   logic [3:0] set_h_ten, set_h_one, set_m_ten, set_m_one, set_s_ten, set_s_one;
   logic       set_load;
   logic [1:0] edit_field;
   logic [5:0] blink_mask;

   modport master (
      output btn_mode, btn_up, btn_down,
      output cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
      input  set_h_ten, set_h_one, set_m_ten, set_m_one, set_s_ten, set_s_one,
      input  set_load, edit_field, blink_mask
   );

   modport slave (
      input  btn_mode, btn_up, btn_down,
      input  cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
      output set_h_ten, set_h_one, set_m_ten, set_m_one, set_s_ten, set_s_one,
      output set_load, edit_field, blink_mask
   );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch time-setting front end: button debounce, hour/minute/second edit FSM, load strobe and blink mask.
// Define WATCH_SET_REPEAT_EN to build auto-repeat for held up/down buttons.
module watch_set_ctrl #(
   parameter int DEBOUNCE_MS  = 20,
   parameter int BLINK_HALF   = 500,
   parameter int EDIT_TIMEOUT = 10000,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 150
) (
   input  logic               clk,
   input  logic               rst,
   watch_set_ctrl_if.slave    bus
);
   localparam int DbW   = $clog2(DEBOUNCE_MS + 1);
   localparam int IdleW = $clog2(EDIT_TIMEOUT + 1);
   localparam int BlW   = $clog2(BLINK_HALF + 1);

   typedef enum logic [1:0] {RUN = 2'd0, EDIT_H = 2'd1, EDIT_M = 2'd2, EDIT_S = 2'd3} state_e;

   // Button vectors are ordered {mode, up, down}.
   logic [2:0]     sync1_q, sync2_q, level_q, levelPrev_q, press_q;
   logic [DbW-1:0] dbCnt_q [3];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         levelPrev_q <= '0;
         press_q     <= '0;
         for (int i = 0; i < 3; i++) dbCnt_q[i] <= '0;
      end else begin
         sync1_q     <= {bus.btn_mode, bus.btn_up, bus.btn_down};
         sync2_q     <= sync1_q;
         levelPrev_q <= level_q;
         press_q     <= level_q & ~levelPrev_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
               if (dbCnt_q[i] == DbW'(DEBOUNCE_MS - 1)) begin
                  level_q[i] <= sync2_q[i];
                  dbCnt_q[i] <= '0;
               end else begin
                  dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
               end
            end else begin
               dbCnt_q[i] <= '0;
            end
         end
      end
   end

   // Out-of-range or non-BCD field values collapse to 00 on the first step.
   function automatic logic [7:0] bcdStep(input logic [3:0] tens, input logic [3:0] ones,
                                          input logic [7:0] maxVal, input logic up);
      logic [7:0] v;
      logic [7:0] n;
      v = {4'd0, tens} * 8'd10 + {4'd0, ones};
      if (tens > 4'd9 || ones > 4'd9 || v > maxVal) n = 8'd0;
      else if (up) n = (v == maxVal) ? 8'd0 : v + 8'd1;
      else         n = (v == 8'd0) ? maxVal : v - 8'd1;
      bcdStep = {4'(n / 8'd10), 4'(n % 8'd10)};
   endfunction

   state_e           state_q, state_d;
   logic [23:0]      edit_q, edit_d;
   logic             load_q, load_d, phase_q, phase_d;
   logic [5:0]       mask_q, mask_d;
   logic [IdleW-1:0] idle_q, idle_d;
   logic [BlW-1:0]   blinkCnt_q, blinkCnt_d;
   logic             modeEv, upEv, dnEv, repUp, repDn, doUp, doDn, stepped;
   logic [3:0]       selTens, selOnes;
   logic [7:0]       selMax, stepVal;

   assign modeEv = press_q[2];
   assign upEv   = press_q[1] & ~press_q[0];
   assign dnEv   = press_q[0] & ~press_q[1];
   assign doUp   = ~modeEv & (upEv | repUp) & ~(dnEv | repDn);
   assign doDn   = ~modeEv & (dnEv | repDn) & ~(upEv | repUp);

`ifdef WATCH_SET_REPEAT_EN
   localparam int RpW = $clog2(REPEAT_DELAY + 1);
   logic [RpW-1:0] repCnt_q, repCnt_d;
   logic           held;

   // repCnt_q counts cycles since the press; zero means no repeat is armed.
   always_comb begin
      held     = level_q[1] ^ level_q[0];
      repUp    = 1'b0;
      repDn    = 1'b0;
      repCnt_d = repCnt_q;
      if (state_q == RUN || modeEv || !held) begin
         repCnt_d = '0;
      end else if (upEv || dnEv) begin
         repCnt_d = RpW'(1);
      end else if (repCnt_q != '0) begin
         if (repCnt_q == RpW'(REPEAT_DELAY)) begin
            repUp    = level_q[1];
            repDn    = level_q[0];
            repCnt_d = RpW'(REPEAT_DELAY - REPEAT_RATE + 1);
         end else begin
            repCnt_d = repCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) repCnt_q <= '0;
      else     repCnt_q <= repCnt_d;
   end
`else
   assign repUp = 1'b0;
   assign repDn = 1'b0;
`endif

   always_comb begin
      case (state_q)
         EDIT_M:  begin selTens = edit_q[15:12]; selOnes = edit_q[11:8];  selMax = 8'd59; end
         EDIT_S:  begin selTens = edit_q[7:4];   selOnes = edit_q[3:0];   selMax = 8'd59; end
         default: begin selTens = edit_q[23:20]; selOnes = edit_q[19:16]; selMax = 8'd23; end
      endcase
      stepVal = bcdStep(selTens, selOnes, selMax, doUp);
   end

   always_comb begin
      state_d    = state_q;
      edit_d     = edit_q;
      load_d     = 1'b0;
      idle_d     = idle_q;
      blinkCnt_d = blinkCnt_q;
      phase_d    = phase_q;
      mask_d     = 6'b0;
      stepped    = (state_q != RUN) && (doUp || doDn);

      case (state_q)
         RUN:     if (modeEv) begin
                     edit_d  = {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten,
                                bus.cur_m_one, bus.cur_s_ten, bus.cur_s_one};
                     state_d = EDIT_H;
                  end
         EDIT_H:  if (modeEv) state_d = EDIT_M;
         EDIT_M:  if (modeEv) state_d = EDIT_S;
         default: if (modeEv) begin
                     state_d = RUN;
                     load_d  = 1'b1;
                  end
      endcase

      if (stepped) begin
         case (state_q)
            EDIT_M:  edit_d[15:8]  = stepVal;
            EDIT_S:  edit_d[7:0]   = stepVal;
            default: edit_d[23:16] = stepVal;
         endcase
      end

      if (state_q == RUN || press_q != 3'b0 || stepped) begin
         idle_d = '0;
      end else if (idle_q == IdleW'(EDIT_TIMEOUT - 1)) begin
         idle_d  = '0;
         state_d = RUN;
      end else begin
         idle_d = idle_q + 1'b1;
      end

      // Phase restarts visible whenever the field changes or a value steps.
      if (state_d == RUN || state_d != state_q || stepped) begin
         blinkCnt_d = '0;
         phase_d    = 1'b0;
      end else if (blinkCnt_q == BlW'(BLINK_HALF - 1)) begin
         blinkCnt_d = '0;
         phase_d    = ~phase_q;
      end else begin
         blinkCnt_d = blinkCnt_q + 1'b1;
      end

      if (phase_d) begin
         case (state_d)
            EDIT_H:  mask_d = 6'b110000;
            EDIT_M:  mask_d = 6'b001100;
            EDIT_S:  mask_d = 6'b000011;
            default: mask_d = 6'b000000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         edit_q     <= '0;
         load_q     <= 1'b0;
         idle_q     <= '0;
         blinkCnt_q <= '0;
         phase_q    <= 1'b0;
         mask_q     <= '0;
      end else begin
         state_q    <= state_d;
         edit_q     <= edit_d;
         load_q     <= load_d;
         idle_q     <= idle_d;
         blinkCnt_q <= blinkCnt_d;
         phase_q    <= phase_d;
         mask_q     <= mask_d;
      end
   end

   assign {bus.set_h_ten, bus.set_h_one, bus.set_m_ten,
           bus.set_m_one, bus.set_s_ten, bus.set_s_one} = edit_q;
   assign bus.set_load   = load_q;
   assign bus.edit_field = state_q;
   assign bus.blink_mask = mask_q;
endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios plus randomized edits against a
// field-level reference model (times held as plain integers).
module tb_watch_set_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   watch_set_ctrl_if bus();

   watch_set_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: current field (0=RUN..3) and edited time as integers.
   int mField, mH, mM, mS;
   int curH, curM, curS;
   int expLoads = 0;
   logic [23:0] expLast = '0;

   // Load monitor
   int loadSeen = 0;
   int doubleLoads = 0;
   logic prevLoad = 1'b0;
   logic [23:0] lastLoad = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [23:0] toBcd(input int h, input int m, input int s);
      toBcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] observedSet();
      observedSet = {bus.set_h_ten, bus.set_h_one, bus.set_m_ten,
                     bus.set_m_one, bus.set_s_ten, bus.set_s_one};
   endfunction

   function automatic int modelStep(input int v, input int maxV, input bit up);
      if (v > maxV) return 0;
      if (up) return (v == maxV) ? 0 : v + 1;
      return (v == 0) ? maxV : v - 1;
   endfunction

   always @(negedge clk) begin
      if (bus.set_load === 1'b1) begin
         loadSeen++;
         lastLoad = observedSet();
         if (prevLoad) doubleLoads++;
      end
      prevLoad = (bus.set_load === 1'b1);
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setCur(input int h, input int m, input int s);
      curH = h; curM = m; curS = s;
      {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten,
       bus.cur_m_one, bus.cur_s_ten, bus.cur_s_one} = toBcd(h, m, s);
   endtask

   task automatic modelPress(input bit m, input bit u, input bit d);
      if (m) begin
         case (mField)
            0: begin mH = curH; mM = curM; mS = curS; mField = 1; end
            1: mField = 2;
            2: mField = 3;
            default: begin mField = 0; expLoads++; expLast = toBcd(mH, mM, mS); end
         endcase
      end else if (u != d && mField != 0) begin
         case (mField)
            1: mH = modelStep(mH, 23, u);
            2: mM = modelStep(mM, 59, u);
            default: mS = modelStep(mS, 59, u);
         endcase
      end
   endtask

   // One clean press (buttons raised together), then release and settle.
   task automatic applyStimulus(input bit m, input bit u, input bit d);
      bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d;
      waitCycles(30);
      bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      waitCycles(35);
      modelPress(m, u, d);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_field"}, 32'(bus.edit_field), 32'(mField));
      checkOutput({tag, "_set"}, 32'(observedSet()), 32'(toBcd(mH, mM, mS)));
   endtask

   task automatic checkLoads(input string tag);
      checkOutput({tag, "_loadCount"}, 32'(loadSeen), 32'(expLoads));
      checkOutput({tag, "_loadValue"}, 32'(lastLoad), 32'(expLast));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int op, nSteps, waited;
      rst = 1'b1;
      bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      setCur(0, 0, 0);
      mField = 0; mH = 0; mM = 0; mS = 0;
      waitCycles(5);
      checkState("reset");
      checkOutput("reset_load", 32'(bus.set_load), 32'd0);
      checkOutput("reset_mask", 32'(bus.blink_mask), 32'd0);
      rst = 1'b0;
      waitCycles(3);

      // Short glitch must not register as a press.
      bus.btn_mode = 1'b1;
      waitCycles(5);
      bus.btn_mode = 1'b0;
      waitCycles(40);
      checkState("glitch");
      checkOutput("glitch_mask", 32'(bus.blink_mask), 32'd0);

      // Full pass through all fields with no edits.
      setCur(12, 34, 56);
      applyStimulus(1, 0, 0);
      checkState("enter");
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkState("editS");
      applyStimulus(1, 0, 0);
      checkState("load1");
      checkLoads("load1");

      // Up/down in RUN is ignored.
      applyStimulus(0, 1, 0);
      checkState("runUp");

      // Wrap boundaries.
      setCur(23, 0, 56);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      checkState("hourWrapUp");
      applyStimulus(0, 0, 1);
      checkState("hourWrapDown");
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      checkState("minWrapDown");
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkLoads("load2");

      // Mode wins over up; up+down cancel.
      setCur(10, 20, 30);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      checkState("modeWins");
      applyStimulus(0, 1, 1);
      checkState("upDownCancel");
      applyStimulus(1, 0, 0);
      checkLoads("load3");

      // Blink cadence and idle timeout, timed from the entry into EDIT_H.
      setCur(7, 8, 9);
      bus.btn_mode = 1'b1;
      waited = 0;
      while (bus.edit_field !== 2'd1 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("blink_enter", 32'(bus.edit_field), 32'd1);
      modelPress(1, 0, 0);
      waitCycles(30);
      bus.btn_mode = 1'b0;
      waitCycles(220);
      checkOutput("blink_250", 32'(bus.blink_mask), 32'h00);
      waitCycles(500);
      checkOutput("blink_750", 32'(bus.blink_mask), 32'h30);
      waitCycles(500);
      checkOutput("blink_1250", 32'(bus.blink_mask), 32'h00);
      waitCycles(500);
      checkOutput("blink_1750", 32'(bus.blink_mask), 32'h30);
      waitCycles(8150);
      checkOutput("timeout_before", 32'(bus.edit_field), 32'd1);
      waitCycles(200);
      mField = 0;
      checkState("timeout_after");
      checkOutput("timeout_mask", 32'(bus.blink_mask), 32'd0);
      checkLoads("timeout");

      // Reset in the middle of an edit discards it.
      setCur(5, 6, 7);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      checkState("preReset");
      rst = 1'b1;
      waitCycles(3);
      rst = 1'b0;
      mField = 0; mH = 0; mM = 0; mS = 0;
      waitCycles(3);
      checkState("midReset");
      checkLoads("midReset");

      // Hold up for ~1000 cycles in EDIT_S starting from 00.
      setCur(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      bus.btn_up = 1'b1;
      waitCycles(1023);
      bus.btn_up = 1'b0;
      waitCycles(40);
      nSteps = 1;
`ifdef WATCH_SET_REPEAT_EN
      for (int t = 500; t < 1000; t += 150) nSteps++;
`endif
      for (int k = 0; k < nSteps; k++) mS = modelStep(mS, 59, 1'b1);
      checkState("hold");
      applyStimulus(1, 0, 0);
      checkLoads("hold");

      // Randomized edit sessions, including out-of-range captured times.
      for (int round = 0; round < 6; round++) begin
         setCur($urandom_range(0, 9) * 10 + $urandom_range(0, 9),
                $urandom_range(0, 9) * 10 + $urandom_range(0, 9),
                $urandom_range(0, 9) * 10 + $urandom_range(0, 9));
         applyStimulus(1, 0, 0);
         checkState("randEnter");
         for (int k = 0; k < 14 && mField != 0; k++) begin
            op = $urandom_range(0, 6);
            case (op)
               0, 1: applyStimulus(0, 1, 0);
               2, 3: applyStimulus(0, 0, 1);
               4:    applyStimulus(0, 1, 1);
               5:    applyStimulus(1, $urandom_range(0, 1), 0);
               default: applyStimulus(1, 0, 0);
            endcase
            checkState("randOp");
         end
         while (mField != 0) applyStimulus(1, 0, 0);
         checkState("randExit");
         checkLoads("rand");
      end

      checkOutput("doubleLoad", 32'(doubleLoads), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
